requant_writeback: RTL and testbench

Requantizes the 32-bit signed partial sums leaving one systolic-array column (PEResult stream) into 8-bit activations. It writes them into the quant feature-map buffer port (BufferRAMTQsize write side) at consecutive addresses. It sits directly downstream of the PE array column and upstream of the quant buffer. It is configured and launched over the CommandDataPort command bus using the REQUANT_MODESET_* codes.

---
 rtl/requant_writeback.sv | 172 +++++++++++++++++
 tb/tb_requant_writeback.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_writeback.sv
// Requantizes one PE-column partial-sum stream to QSIZE-bit activations and writes
// them to consecutive quant-buffer addresses through a fixed 3-stage pipeline.
module requant_writeback #(
    parameter int RSIZE  = 32,
    parameter int QSIZE  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_command,
    input  logic [31:0]       cmd_data0,
    input  logic [31:0]       cmd_data1,
    input  logic              res_valid,
    input  logic [RSIZE-1:0]  res_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [QSIZE-1:0]  wr_data,
    output logic [3:0]        state,
    output logic              done
);
    typedef enum logic [3:0] {
        REQUANT_IDLE    = 4'd0,
        REQUANT_WORKING = 4'd1
    } state_t;

    localparam logic [7:0] ACCUM_CONV0        = 8'd1;
    localparam logic [7:0] ACCUM_CONV1        = 8'd2;
    localparam logic [7:0] ACCUM_CONV2        = 8'd3;
    localparam logic [7:0] ACCUM_CONV3        = 8'd4;
    localparam logic [7:0] ACCUM_CONV_LAYERID = 8'd7;
    localparam logic [5:0] S_MAX              = 6'd47;
    localparam logic signed [49:0] Q_MAX = (50'sd1 <<< (QSIZE - 1)) - 50'sd1;
    localparam logic signed [49:0] Q_MIN = -(50'sd1 <<< (QSIZE - 1));

    state_t                    state_q;
    logic [ADDR_W-1:0]         base_q;
    logic [ADDR_W:0]           count_q;
    logic [ADDR_W:0]           acc_cnt;
    logic signed [15:0]        m_q;
    logic [5:0]                s_q;
    logic signed [7:0]         zp_q;
    logic                      act_q;
    logic signed [31:0]        bias_q;

    logic                      s1_v;
    logic signed [31:0]        s1_t;
    logic [ADDR_W-1:0]         s1_addr;
    logic                      s2_v;
    logic signed [47:0]        s2_p;
    logic [ADDR_W-1:0]         s2_addr;

    logic                      accept;
    logic signed [32:0]        sum1;
    logic signed [31:0]        t1;
    logic signed [48:0]        half;
    logic signed [48:0]        shifted;
    logic signed [48:0]        relu;
    logic signed [49:0]        v;
    logic [QSIZE-1:0]          q;
    logic                      unused_cmd_bits;

    assign unused_cmd_bits = ^cmd_data1[31:ADDR_W+1];
    assign state  = state_q;
    assign accept = (state_q == REQUANT_WORKING) && res_valid && (acc_cnt < count_q);

    // Stage 1 input: bias add in 33 bits, saturated back to 32.
    always_comb begin
        sum1 = 33'(signed'(res_data)) + 33'(bias_q);
        if (sum1[32] != sum1[31]) begin
            t1 = sum1[32] ? {1'b1, 31'd0} : {1'b0, {31{1'b1}}};
        end else begin
            t1 = sum1[31:0];
        end
    end

    // Stage 3 input: 49 bits leave headroom for the rounding add on the extreme product.
    always_comb begin
        half    = (s_q == 6'd0) ? '0 : (49'sd1 <<< (s_q - 6'd1));
        shifted = (49'(s2_p) + half) >>> s_q;
        relu    = (act_q && shifted[48]) ? '0 : shifted;
        v       = 50'(relu) + 50'(zp_q);
        if (v > Q_MAX) begin
            q = Q_MAX[QSIZE-1:0];
        end else if (v < Q_MIN) begin
            q = Q_MIN[QSIZE-1:0];
        end else begin
            q = v[QSIZE-1:0];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the synchronous reset clears config and every pipeline valid, so a
        // result in flight when reset arrives can never produce a later write.
        if (!rstn) begin
            state_q <= REQUANT_IDLE;
            base_q  <= '0;
            count_q <= '0;
            m_q     <= 16'sd1;
            s_q     <= '0;
            zp_q    <= '0;
            act_q   <= 1'b0;
            bias_q  <= '0;
            acc_cnt <= '0;
            s1_v    <= 1'b0;
            s1_t    <= '0;
            s1_addr <= '0;
            s2_v    <= 1'b0;
            s2_p    <= '0;
            s2_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            done  <= 1'b0;
            s1_v  <= accept;
            s2_v  <= s1_v;
            wr_en <= s2_v;
            if (accept) begin
                s1_t    <= t1;
                s1_addr <= base_q + acc_cnt[ADDR_W-1:0];
                acc_cnt <= acc_cnt + {{ADDR_W{1'b0}}, 1'b1};
            end
            s2_p    <= 48'(s1_t) * 48'(m_q);
            s2_addr <= s1_addr;
            if (s2_v) begin
                wr_addr <= s2_addr;
                wr_data <= q;
            end

            case (state_q)
                REQUANT_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_command)
                            ACCUM_CONV0: begin
                                base_q  <= cmd_data0[ADDR_W-1:0];
                                count_q <= cmd_data1[ADDR_W:0];
                            end
                            ACCUM_CONV1: begin
                                m_q <= cmd_data0[15:0];
                                s_q <= (cmd_data1[5:0] > S_MAX) ? S_MAX : cmd_data1[5:0];
                            end
                            ACCUM_CONV2: begin
                                zp_q  <= cmd_data0[7:0];
                                act_q <= cmd_data1[0];
                            end
                            ACCUM_CONV3: bias_q <= cmd_data0;
                            ACCUM_CONV_LAYERID: begin
                                acc_cnt <= '0;
                                // An empty run completes immediately without leaving IDLE.
                                if (count_q == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    state_q <= REQUANT_WORKING;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                REQUANT_WORKING: begin
                    if ((acc_cnt == count_q) && !s1_v && !s2_v) begin
                        done    <= 1'b1;
                        state_q <= REQUANT_IDLE;
                    end
                end
                default: state_q <= REQUANT_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_requant_writeback.sv
// Bench for requant_writeback: directed and randomized runs compared every cycle
// against an arithmetic model that schedules each expected write by cycle number.
module tb_requant_writeback;
    localparam int RSIZE  = 32;
    localparam int QSIZE  = 8;
    localparam int ADDR_W = 16;
    localparam logic [7:0] C_CONV0 = 8'd1;
    localparam logic [7:0] C_CONV1 = 8'd2;
    localparam logic [7:0] C_CONV2 = 8'd3;
    localparam logic [7:0] C_CONV3 = 8'd4;
    localparam logic [7:0] C_START = 8'd7;
    localparam longint SAT_HI = 64'sd2147483647;
    localparam longint SAT_LO = -64'sd2147483648;

    logic              clk = 1'b0;
    logic              rstn;
    logic              cmd_valid;
    logic [7:0]        cmd_command;
    logic [31:0]       cmd_data0;
    logic [31:0]       cmd_data1;
    logic              res_valid;
    logic [RSIZE-1:0]  res_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [QSIZE-1:0]  wr_data;
    logic [3:0]        state;
    logic              done;

    always #5 clk = ~clk;

    requant_writeback #(.RSIZE(RSIZE), .QSIZE(QSIZE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_command(cmd_command),
        .cmd_data0(cmd_data0), .cmd_data1(cmd_data1),
        .res_valid(res_valid), .res_data(res_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .state(state), .done(done)
    );

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Model: config, run progress, and expected outputs keyed by the edge after which they appear.
    int m_base, m_count, m_m, m_s, m_zp, m_bias, m_acc, m_end;
    bit m_act, m_working;
    int exp_addr[int];
    int exp_data[int];
    bit exp_done[int];
    int obs_addr[$];
    int obs_data[$];
    int done_cnt = 0;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_mis++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, got, expv);
        end
    endtask

    function automatic int requant_f(input int res, input int bias, input int m,
                                     input int s, input int zp, input bit act);
        longint t, p, r, val;
        t = longint'(res) + longint'(bias);
        if (t > SAT_HI) t = SAT_HI;
        if (t < SAT_LO) t = SAT_LO;
        p = t * longint'(m);
        r = (s == 0) ? p : ((p + (64'sd1 <<< (s - 1))) >>> s);
        if (act && r < 0) r = 0;
        val = r + longint'(zp);
        if (val > 127) val = 127;
        if (val < -128) val = -128;
        return int'(val);
    endfunction

    task automatic model_edge();
        bit was_working;
        cyc++;
        if (!rstn) begin
            m_base = 0; m_count = 0; m_m = 1; m_s = 0; m_zp = 0; m_act = 0; m_bias = 0;
            m_working = 0; m_acc = 0; m_end = -1;
            exp_addr.delete(); exp_data.delete(); exp_done.delete();
            return;
        end
        was_working = m_working;
        if (was_working && cyc == m_end) begin
            m_working = 0;
            exp_done[cyc] = 1;
        end
        if (!was_working && cmd_valid) begin
            case (cmd_command)
                C_CONV0: begin
                    m_base  = 32'(cmd_data0[15:0]);
                    m_count = 32'(cmd_data1[16:0]);
                end
                C_CONV1: begin
                    m_m = 32'($signed(cmd_data0[15:0]));
                    m_s = (cmd_data1[5:0] > 6'd47) ? 47 : 32'(cmd_data1[5:0]);
                end
                C_CONV2: begin
                    m_zp  = 32'($signed(cmd_data0[7:0]));
                    m_act = cmd_data1[0];
                end
                C_CONV3: m_bias = cmd_data0;
                C_START: begin
                    m_acc = 0;
                    if (m_count == 0) exp_done[cyc] = 1;
                    else begin
                        m_working = 1;
                        m_end = -1;
                    end
                end
                default: ;
            endcase
        end
        if (was_working && res_valid && m_acc < m_count) begin
            exp_addr[cyc + 2] = (m_base + m_acc) % 65536;
            exp_data[cyc + 2] = requant_f(res_data, m_bias, m_m, m_s, m_zp, m_act);
            m_acc++;
            if (m_acc == m_count) m_end = cyc + 3;
        end
    endtask

    task automatic compare();
        bit ew, ed;
        ew = exp_data.exists(cyc);
        ed = exp_done.exists(cyc);
        check("state", state, m_working ? 1 : 0);
        check("done", done, ed);
        check("wr_en", wr_en, ew);
        if (ew) begin
            check("wr_addr", wr_addr, exp_addr[cyc]);
            check("wr_data", $signed(wr_data), exp_data[cyc]);
            exp_addr.delete(cyc);
            exp_data.delete(cyc);
        end
        if (ed) exp_done.delete(cyc);
        if (wr_en === 1'b1) begin
            obs_addr.push_back(32'(wr_addr));
            obs_data.push_back(32'($signed(wr_data)));
        end
        if (done === 1'b1) done_cnt++;
    endtask

    // One clock: model sees the inputs the DUT samples, outputs are checked mid-cycle.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [31:0] d0, input logic [31:0] d1);
        cmd_valid = 1'b1; cmd_command = c; cmd_data0 = d0; cmd_data1 = d1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic send_res(input int val);
        res_valid = 1'b1; res_data = val;
        step();
        res_valid = 1'b0;
    endtask

    task automatic start_run(input int base, input int cnt, input int m, input int s,
                             input int zp, input int act, input int bias);
        send_cmd(C_CONV0, base, cnt);
        send_cmd(C_CONV1, m, s);
        send_cmd(C_CONV2, zp, act);
        send_cmd(C_CONV3, bias, 0);
        send_cmd(C_START, 0, 0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((m_working || exp_data.num() != 0 || exp_done.num() != 0) && k < 200) begin
            step();
            k++;
        end
        check("drain_timeout", (k < 200), 1);
        step();
        step();
    endtask

    task automatic check_write(input string name, input int idx, input int ea, input int ed);
        check({name, "_present"}, (idx < obs_data.size()), 1);
        if (idx < obs_data.size()) begin
            check({name, "_addr"}, obs_addr[idx], ea);
            check({name, "_data"}, obs_data[idx], ed);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mark, dmark;
        cmd_valid = 0; cmd_command = 0; cmd_data0 = 0; cmd_data1 = 0;
        res_valid = 0; res_data = 0; rstn = 0;
        step();
        step();
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_done", done, 0);
        check("rst_state", state, 0);
        rstn = 1;
        step();

        // Hand-computed anchors for the model itself.
        check("pin_scale", requant_f(100, 0, 3, 2, 0, 0), 75);
        check("pin_round_neg", requant_f(-10, 0, 3, 2, 0, 0), -7);
        check("pin_sat_neg", requant_f(-1000, 0, 1, 0, 0, 0), -128);
        check("pin_relu", requant_f(-50, 0, 1, 0, 5, 1), 5);
        check("pin_no_relu", requant_f(-50, 0, 1, 0, 5, 0), -45);
        check("pin_stage1_clamp", requant_f(32'h7FFFFFF0, 256, 1, 32, 0, 0), 0);

        // Basic scaling
        mark = obs_data.size(); dmark = done_cnt;
        start_run(32'h100, 4, 3, 2, 0, 0, 0);
        res_valid = 1;
        res_data = 100; step();
        res_data = 4;   step();
        res_data = -10; step();
        res_data = 0;   step();
        res_valid = 0;
        drain();
        check("basic_nwrites", obs_data.size() - mark, 4);
        check_write("basic_w0", mark,     32'h100, 75);
        check_write("basic_w1", mark + 1, 32'h101, 3);
        check_write("basic_w2", mark + 2, 32'h102, -7);
        check_write("basic_w3", mark + 3, 32'h103, 0);
        check("basic_done_cnt", done_cnt - dmark, 1);

        // Saturation
        mark = obs_data.size();
        start_run(0, 2, 1, 0, 0, 0, 0);
        send_res(1000);
        send_res(-1000);
        drain();
        check_write("sat_pos", mark, 0, 127);
        check_write("sat_neg", mark + 1, 1, -128);
        mark = obs_data.size();
        start_run(0, 1, 1, 0, 0, 0, 32'h100);
        send_res(32'h7FFFFFF0);
        drain();
        check_write("sat_bias", mark, 0, 127);
        mark = obs_data.size();
        start_run(0, 1, 1, 32, 0, 0, 32'h100);
        send_res(32'h7FFFFFF0);
        drain();
        check_write("sat_stage1_shift", mark, 0, 0);

        // ReLU and zero point
        mark = obs_data.size();
        start_run(0, 2, 1, 0, 5, 1, 0);
        send_res(-50);
        send_res(20);
        drain();
        check_write("relu_neg", mark, 0, 5);
        check_write("relu_pos", mark + 1, 1, 25);
        mark = obs_data.size();
        start_run(0, 2, 1, 0, 5, 0, 0);
        send_res(-50);
        send_res(20);
        drain();
        check_write("norelu_neg", mark, 0, -45);
        check_write("norelu_pos", mark + 1, 1, 25);

        // Count limit, overrun results and a mid-run start
        mark = obs_data.size(); dmark = done_cnt;
        start_run(32'h20, 2, 1, 0, 0, 0, 0);
        res_valid = 1;
        res_data = 11; step();
        res_data = 12; step();
        res_data = 13; cmd_valid = 1; cmd_command = C_START; step();
        cmd_valid = 0;
        res_data = 14; step();
        res_valid = 0;
        drain();
        send_res(99);
        send_res(98);
        step(); step(); step();
        check("ovr_nwrites", obs_data.size() - mark, 2);
        check_write("ovr_w0", mark, 32'h20, 11);
        check_write("ovr_w1", mark + 1, 32'h21, 12);
        check("ovr_done_cnt", done_cnt - dmark, 1);
        check("ovr_state", state, 0);

        // Empty run
        mark = obs_data.size(); dmark = done_cnt;
        start_run(0, 0, 1, 0, 0, 0, 0);
        drain();
        check("cnt0_nwrites", obs_data.size() - mark, 0);
        check("cnt0_done_cnt", done_cnt - dmark, 1);

        // Address wrap
        mark = obs_data.size();
        start_run(32'hFFFE, 3, 1, 0, 0, 0, 0);
        send_res(1);
        send_res(2);
        send_res(3);
        drain();
        check_write("wrap_w0", mark,     32'hFFFE, 1);
        check_write("wrap_w1", mark + 1, 32'hFFFF, 2);
        check_write("wrap_w2", mark + 2, 32'h0000, 3);

        // Reset with two results in flight, then a run on default config
        start_run(32'h40, 4, 5, 0, 0, 0, 0);
        send_res(1);
        send_res(2);
        mark = obs_data.size(); dmark = done_cnt;
        rstn = 0;
        step();
        rstn = 1;
        repeat (6) step();
        check("rstmid_nwrites", obs_data.size() - mark, 0);
        check("rstmid_done_cnt", done_cnt - dmark, 0);
        check("rstmid_state", state, 0);
        send_cmd(C_CONV0, 0, 1);
        send_cmd(C_START, 0, 0);
        send_res(7);
        drain();
        check_write("rstmid_default_m", mark, 0, 7);

        // Randomized runs with concurrent, ignored commands and junk codes
        for (int r = 0; r < 40; r++) begin
            int k;
            int bias, m, base;
            case ($urandom_range(0, 3))
                0: bias = 0;
                1: bias = int'($urandom_range(0, 2000)) - 1000;
                2: bias = int'($urandom);
                default: bias = $urandom_range(0, 1) ? 32'h7FFFFF00 : 32'h80000100;
            endcase
            m = $urandom_range(0, 1) ? int'($urandom_range(0, 40)) - 20 : int'($urandom);
            base = $urandom_range(0, 1) ? int'($urandom) : 32'hFFF8 + int'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) send_cmd(8'($urandom_range(8, 255)), $urandom, $urandom);
            start_run(base, $urandom_range(0, 10), m, $urandom_range(0, 63),
                      $urandom, $urandom_range(0, 1), bias);
            k = 0;
            while (m_working && m_acc < m_count && k < 100) begin
                res_valid = ($urandom_range(0, 3) != 0);
                res_data  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 600) - 300;
                cmd_valid = ($urandom_range(0, 6) == 0);
                cmd_command = 8'($urandom_range(0, 8));
                cmd_data0 = $urandom;
                cmd_data1 = $urandom;
                step();
                k++;
            end
            cmd_valid = 0;
            check("rand_stream_timeout", (k < 100), 1);
            repeat ($urandom_range(0, 3)) begin
                res_valid = 1;
                res_data = $urandom;
                step();
            end
            res_valid = 0;
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
